// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter and sequencer for a single-port RAM.
// Each transaction runs IDLE -> ACCESS -> CAPTURE -> RESP. The grant, the
// RAM strobes, the captured read data and the ack pulse are all registered.
module ram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0 (instruction fetch)
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1 (load/store or debug)
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  // RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              sel_q, sel_d;                 // id of the master being served
  logic              last_grant_q, last_grant_d;   // id of the most recent grant
  logic              we_lat_q, we_lat_d;           // latched direction of the transaction
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              grant_m1;

  // Choose the winner among the requests present this cycle.
  // On a tie in round-robin mode the master that was not granted last wins.
  always_comb begin
    grant_m1 = 1'b0;
    if (m0_req && m1_req) begin
      grant_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      grant_m1 = m1_req;
    end
  end

  // Next-state and registered-output logic of the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_grant_d  = last_grant_q;
    we_lat_d      = we_lat_q;
    ram_addr_d    = ram_addr_q;      // address/data hold between transactions
    ram_data_in_d = ram_data_in_q;
    ram_we_d      = 1'b0;            // strobes are only ever high in ACCESS
    ram_re_d      = 1'b0;
    m0_ack_d      = 1'b0;            // acks are single-cycle pulses
    m1_ack_d      = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          sel_d         = grant_m1;
          last_grant_d  = grant_m1;
          we_lat_d      = grant_m1 ? m1_we : m0_we;
          ram_addr_d    = grant_m1 ? m1_addr : m0_addr;
          ram_data_in_d = grant_m1 ? m1_wdata : m0_wdata;
          ram_we_d      = grant_m1 ? m1_we : m0_we;
          ram_re_d      = grant_m1 ? ~m1_we : ~m0_we;
          state_d       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The RAM registered data_out on the edge that ended ACCESS.
        if (!we_lat_q) begin
          if (sel_q) begin
            m1_rdata_d = ram_data_out;
          end else begin
            m0_rdata_d = ram_data_out;
          end
        end
        m0_ack_d = ~sel_q;
        m1_ack_d = sel_q;
        state_d  = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= 1'b0;
      last_grant_q  <= 1'b1;   // so master 0 wins the first tie
      we_lat_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_grant_q  <= last_grant_d;
      we_lat_q      <= we_lat_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      busy_q        <= busy_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_we      = ram_we_q;
  assign ram_re      = ram_re_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign busy        = busy_q;

endmodule
